// File: rtl/cmd_pkg.sv
// rtl/cmd_pkg.sv - shared assembler state type and command opcodes
// Purpose: types and constants shared by the command assembler and the command decoder.
// Contents: asm_state_t (assembler FSM states), OP_* opcodes (first byte of a command).
package cmd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BYTE2 = 2'd1,
        BYTE3 = 2'd2,
        FULL  = 2'd3
    } asm_state_t;

    localparam logic [7:0] OP_READ   = 8'h02;
    localparam logic [7:0] OP_WRITE  = 8'h06;
    localparam logic [7:0] OP_STATUS = 8'h07;
    localparam logic [7:0] OP_RESET  = 8'h09;

endpackage

// File: rtl/resp_tx_ctrl.sv
// rtl/resp_tx_ctrl.sv - response byte hand-off to the UART transmitter
// Purpose: latches one response byte, starts the transmitter and reports completion.
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   send_resp        request to send resp_data (ignored while busy)
//   resp_data[7:0]   response byte
//   tx_done          transmitter finished (ignored while idle)
//   trmt             one-cycle start pulse, one cycle after an accepted send_resp
//   tx_data[7:0]     latched response byte
//   resp_sent        one-cycle completion pulse, combinational from tx_done
module resp_tx_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       send_resp,
    input  logic [7:0] resp_data,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       resp_sent
);

    logic       busy_q;
    logic       trmt_q;
    logic [7:0] tx_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q    <= 1'b0;
            trmt_q    <= 1'b0;
            tx_data_q <= 8'h00;
        end else begin
            trmt_q <= 1'b0;
            if (!busy_q) begin
                if (send_resp) begin
                    tx_data_q <= resp_data;
                    busy_q    <= 1'b1;
                    trmt_q    <= 1'b1;
                end
            end else if (tx_done) begin
                busy_q <= 1'b0;
            end
        end
    end

    assign trmt      = trmt_q;
    assign tx_data   = tx_data_q;
    // busy is cleared asynchronously by reset, so this is also low during reset
    assign resp_sent = busy_q & tx_done;

endmodule

// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - assembles 3-byte UART commands and forwards responses
// Purpose: collects three received bytes into a 24-bit command, hands it to the decoder,
//          and drops a partial command when the gap between bytes exceeds TIMEOUT_CYC.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   rx_rdy, rx_data   receiver holds a byte / the byte
//   clr_rx_rdy        combinational pulse consuming the receiver byte
//   cmd[23:0]         assembled command, first byte in [23:16]
//   cmd_rdy           registered; cmd is complete
//   clr_cmd_rdy       decoder releases cmd (only meaningful while complete)
//   send_resp, resp_data, tx_done, trmt, tx_data, resp_sent   response path
module uart_cmd_assembler
    import cmd_pkg::*;
#(
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    output logic [23:0] cmd,
    output logic        cmd_rdy,
    input  logic        clr_cmd_rdy,
    input  logic        send_resp,
    input  logic [7:0]  resp_data,
    output logic        trmt,
    output logic [7:0]  tx_data,
    input  logic        tx_done,
    output logic        resp_sent
);

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TMO_MAX = CNT_W'(TIMEOUT_CYC);

    asm_state_t       state_q, state_d;
    logic [CNT_W-1:0] tmo_cnt_q;
    logic [23:0]      cmd_q;
    logic             cmd_rdy_q;
    logic             accept;
    logic             timed_out;
    logic             waiting;

    assign waiting = (state_q == BYTE2) || (state_q == BYTE3);

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        timed_out = 1'b0;
        case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    accept  = 1'b1;
                    state_d = BYTE2;
                end
            end
            BYTE2: begin
                if (rx_rdy) begin
                    accept  = 1'b1;
                    state_d = BYTE3;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            BYTE3: begin
                if (rx_rdy) begin
                    accept  = 1'b1;
                    state_d = FULL;
                end else if (tmo_cnt_q == TMO_MAX) begin
                    timed_out = 1'b1;
                    state_d   = IDLE;
                end
            end
            FULL: begin
                // the pending receiver byte waits; it is taken in the next IDLE cycle
                if (clr_cmd_rdy) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cmd_q     <= 24'h000000;
            cmd_rdy_q <= 1'b0;
            tmo_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            cmd_rdy_q <= (state_d == FULL);
            if (accept) begin
                case (state_q)
                    IDLE:    cmd_q[23:16] <= rx_data;
                    BYTE2:   cmd_q[15:8]  <= rx_data;
                    default: cmd_q[7:0]   <= rx_data;
                endcase
            end
            // a byte arriving on the terminal count is accepted instead of timing out
            if (accept || timed_out) begin
                tmo_cnt_q <= '0;
            end else if (waiting && (tmo_cnt_q != TMO_MAX)) begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
        end
    end

    // state is already IDLE during reset, so the byte must be masked explicitly
    assign clr_rx_rdy = accept & rst_n;
    assign cmd        = cmd_q;
    assign cmd_rdy    = cmd_rdy_q;

    resp_tx_ctrl u_resp_tx_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .send_resp (send_resp),
        .resp_data (resp_data),
        .tx_done   (tx_done),
        .trmt      (trmt),
        .tx_data   (tx_data),
        .resp_sent (resp_sent)
    );

endmodule

// File: doc/uart_cmd_assembler.md
UART_CMD_ASSEMBLER -- requirements
Module: uart_cmd_assembler

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYC, default 50000; it is the maximum idle cycles allowed between bytes of one command.
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock; all logic on its rising edge
- rst_n  in  1  reset; asynchronous, active-low
- rx_rdy  in  1  UART receiver holds a byte
- rx_data  in  8  received byte
- clr_rx_rdy  out  1  one-cycle pulse; consumes the byte at the receiver
- cmd  out  24  assembled command; first byte at [23:16], last byte at [7:0]
- cmd_rdy  out  1  cmd is valid for the command decoder
- clr_cmd_rdy  in  1  decoder is done with cmd
- send_resp  in  1  decoder requests a response byte
- resp_data  in  8  response byte
- trmt  out  1  one-cycle start pulse to the UART transmitter
- tx_data  out  8  byte sent to the transmitter
- tx_done  in  1  transmitter has finished the byte
- resp_sent  out  1  one-cycle pulse; response complete

Function
REQ-003 The assembler FSM SHALL have four states: IDLE, BYTE2, BYTE3, FULL.
REQ-004 In IDLE with rx_rdy=1, the block SHALL assert clr_rx_rdy combinationally that cycle, load rx_data into cmd[23:16], and go to BYTE2.
REQ-005 In BYTE2 with rx_rdy=1, the block SHALL assert clr_rx_rdy, load cmd[15:8], and go to BYTE3.
REQ-006 In BYTE3 with rx_rdy=1, the block SHALL assert clr_rx_rdy, load cmd[7:0], and go to FULL.
REQ-007 cmd_rdy SHALL be registered: high from the first cycle in FULL until clr_cmd_rdy is sampled high.
REQ-008 In FULL, clr_rx_rdy SHALL stay low and the pending byte SHALL remain at the receiver.
REQ-009 In FULL with clr_cmd_rdy=1, the block SHALL go to IDLE with cmd_rdy=0 on the next cycle.
  - If rx_rdy=1 in the same cycle, that byte SHALL be accepted in the following IDLE cycle.
REQ-010 clr_cmd_rdy outside FULL SHALL have no effect.
REQ-011 cmd SHALL hold its value after clearing, and only the byte field being loaded SHALL change.
REQ-012 The timeout counter:
  - clears on every accepted byte;
  - counts each cycle in BYTE2 or BYTE3 while rx_rdy=0;
  - at TIMEOUT_CYC, the state SHALL return to IDLE and the partial command is discarded, with cmd_rdy never asserted.
REQ-013 If a byte arrives in the same cycle the counter reaches TIMEOUT_CYC, the byte SHALL win.
REQ-014 The counter width SHALL be $clog2(TIMEOUT_CYC+1), and the counter SHALL saturate, never wrap.
REQ-015 Response path, when not busy:
  - send_resp=1 SHALL latch resp_data into tx_data, set busy, and pulse trmt on the next cycle (latency 1).
REQ-016 Response path, when busy:
  - tx_done=1 SHALL clear busy and pulse resp_sent in the same cycle (combinational from tx_done and busy).
REQ-017 send_resp while busy SHALL be ignored; tx_done while not busy SHALL be ignored.
REQ-018 The response path SHALL operate independently of the assembler FSM; both may be active at once.

Reset
REQ-019 On rst_n=0, the block SHALL immediately force:
  - state = IDLE, cmd = 24'h000000, cmd_rdy = 0;
  - timeout counter = 0, tx_data = 8'h00, busy = 0, trmt = 0.
REQ-020 Reset mid-command SHALL discard received bytes.
REQ-021 clr_rx_rdy and resp_sent SHALL be 0 during reset.

Structure
REQ-022 The state enum (asm_state_t) SHALL live in shared package cmd_pkg; command opcode localparams SHALL move there too for decoder reuse.
REQ-023 The response path SHALL be sub-module resp_tx_ctrl (send_resp, resp_data, tx_done -> trmt, tx_data, resp_sent).
REQ-024 All remaining logic SHALL be in the top module; the expected size is 120-250 lines.

Verification
REQ-025 Bytes 02, 0D, 00 with 3-cycle gaps -> three clr_rx_rdy pulses, then cmd=24'h020D00 and cmd_rdy=1 one cycle after the third pulse.
REQ-026 With TIMEOUT_CYC=20: byte 06, 25-cycle gap, then 07, 00, 00 -> cmd_rdy only after the third byte of the second group, cmd=24'h070000.
REQ-027 While FULL: rx_rdy=1 with byte AA for 10 cycles -> no clr_rx_rdy. Then clr_cmd_rdy -> IDLE, and AA is accepted into cmd[23:16] two cycles later.
REQ-028 send_resp with A5 -> trmt pulse one cycle later, tx_data=8'hA5. A second send_resp with EE before tx_done -> ignored. tx_done -> single resp_sent pulse.
REQ-029 rst_n=0 after two bytes, released, then bytes 09, 05, 00 -> cmd=24'h090500, with no residue from the earlier bytes.
REQ-030 Byte 3 arrives exactly at count TIMEOUT_CYC -> byte accepted and cmd_rdy=1.
